// File: rtl/ssd_pkg.sv
// Shared constants and state encoding for the seven-segment display arbiter.
// Optional client-0 priority is selected with the SSD_ARB_PRIO_EN macro.
package ssd_pkg;

    localparam logic [3:0]  BLANK_NIB  = 4'hF;
    localparam logic [15:0] BLANK_WORD = {4{BLANK_NIB}};

    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_e;

    function automatic logic [15:0] owner_word(input state_e st,
                                               input logic [15:0] w0,
                                               input logic [15:0] w1);
        logic [15:0] w;
        w = BLANK_WORD;
        if (st == OWN0) w = w0;
        else if (st == OWN1) w = w1;
        return w;
    endfunction

endpackage

// File: rtl/ssd_tick_gen.sv
// Free-running slow-tick divider: one-cycle pulse every TICK_DIV clocks.
// Latency: tick is decoded from the registered count; no backpressure, never stalls.
module ssd_tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/ssd_display_arbiter.sv
// Round-robin owner of the 4-digit display with a minimum hold in slow ticks.
// Latency: grant/nums update one edge after req/data; requesters wait (req level held) until granted.
// SSD_ARB_PRIO_EN: client 0 preempts client 1 and wins idle ties.
module ssd_display_arbiter
    import ssd_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int HOLD_TICKS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [15:0] nums0,
    input  logic [15:0] nums1,
    output logic [1:0]  grant,
    output logic [15:0] nums,
    output logic        tick
);

`ifdef SSD_ARB_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          last_q, last_d;
    logic [1:0]    grant_q, grant_d;
    logic [15:0]   nums_q, nums_d;
    logic          hold_full;

    ssd_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign hold_full = (hold_q == HOLD_MAX);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (req[0] && req[1]) begin
                    state_d = (PRIO_EN || last_q == CLIENT1) ? OWN0 : OWN1;
                end else if (req[0]) begin
                    state_d = OWN0;
                end else if (req[1]) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!req[0]) begin
                    state_d = req[1] ? OWN1 : IDLE;
                end else if (req[1] && hold_full) begin
                    state_d = OWN1;
                end
            end
            OWN1: begin
                if (!req[1]) begin
                    state_d = req[0] ? OWN0 : IDLE;
                end else if (req[0] && (PRIO_EN || hold_full)) begin
                    state_d = OWN0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Hold restarts on every ownership change; it only counts while owned.
        if (state_d != state_q || state_d == IDLE) begin
            hold_d = '0;
        end else if (tick && !hold_full) begin
            hold_d = hold_q + HW'(1);
        end

        if (state_d != state_q) begin
            if (state_d == OWN0) last_d = CLIENT0;
            if (state_d == OWN1) last_d = CLIENT1;
        end

        grant_d = state_d;
        nums_d  = owner_word(state_d, nums0, nums1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            last_q  <= CLIENT1;
            grant_q <= 2'b00;
            nums_q  <= BLANK_WORD;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            nums_q  <= nums_d;
        end
    end

    assign grant = grant_q;
    assign nums  = nums_q;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Directed bench for ssd_display_arbiter with TICK_DIV=4, HOLD_TICKS=2.
module tb_ssd_display_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [15:0] nums0;
    logic [15:0] nums1;
    logic [1:0]  grant;
    logic [15:0] nums;
    logic        tick;

    int n_cmp = 0;
    int n_err = 0;

    ssd_display_arbiter #(
        .TICK_DIV  (4),
        .HOLD_TICKS(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .nums0(nums0),
        .nums1(nums1),
        .grant(grant),
        .nums (nums),
        .tick (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges and verify outputs clear without a clock.
    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_grant"}, {14'd0, grant}, 16'h0000);
        chk({tag, "_nums"}, nums, 16'hFFFF);
        chk({tag, "_tick"}, {15'd0, tick}, 16'h0000);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 2'b00;
        nums0 = 16'h0000;
        nums1 = 16'h0000;

        // Reset and idle: tick on every 4th edge.
        step();
        chk("rst_grant", {14'd0, grant}, 16'h0000);
        chk("rst_nums", nums, 16'hFFFF);
        chk("rst_tick", {15'd0, tick}, 16'h0000);
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("idle_tick_%0d", k), {15'd0, tick}, {15'd0, (k % 4 == 3)});
            chk($sformatf("idle_grant_%0d", k), {14'd0, grant}, 16'h0000);
        end

        // Mid-count reset clears tick immediately and restarts the divider.
        step(); step(); step();
        chk("pre_midrst_tick", {15'd0, tick}, 16'h0001);
        reset_pulse("midrst");
        step(); chk("post_midrst_t1", {15'd0, tick}, 16'h0000);
        step(); chk("post_midrst_t2", {15'd0, tick}, 16'h0000);
        step(); chk("post_midrst_t3", {15'd0, tick}, 16'h0001);

        // Single requester; data follows one cycle later.
        nums0 = 16'h0123;
        req   = 2'b01;
        step();
        chk("own0_grant", {14'd0, grant}, 16'h0001);
        chk("own0_nums", nums, 16'h0123);
        nums0 = 16'h1234;
        step();
        chk("own0_data", nums, 16'h1234);
        req = 2'b00;
        step();
        chk("rel0_grant", {14'd0, grant}, 16'h0000);
        chk("rel0_nums", nums, 16'hFFFF);

        // Contention from fresh reset: client 0 first, switch after 2 ticks.
        reset_pulse("rst2");
        nums1 = 16'hABCD;
        req   = 2'b11;
        step();
        chk("tie_grant", {14'd0, grant}, 16'h0001);
        chk("tie_nums", nums, 16'h1234);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("hold0_%0d", k), {14'd0, grant}, (k == 8) ? 16'h0002 : 16'h0001);
        end
        chk("sw1_nums", nums, 16'hABCD);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("hold1_%0d", k), {14'd0, grant}, (k == 8) ? 16'h0001 : 16'h0002);
        end
        chk("sw0_nums", nums, 16'h1234);

        // Drop owner before hold expires: immediate hand-over, then idle.
        req = 2'b10;
        step();
        chk("drop0_grant", {14'd0, grant}, 16'h0002);
        chk("drop0_nums", nums, 16'hABCD);
        req = 2'b00;
        step();
        chk("drop1_grant", {14'd0, grant}, 16'h0000);
        chk("drop1_nums", nums, 16'hFFFF);

        // Client 1 owns at hold 0, then client 0 asks.
        req = 2'b10;
        step();
        chk("own1_grant", {14'd0, grant}, 16'h0002);
        req = 2'b11;
`ifdef SSD_ARB_PRIO_EN
        step();
        chk("preempt_grant", {14'd0, grant}, 16'h0001);
        chk("preempt_nums", nums, 16'h1234);
        for (int k = 2; k <= 9; k++) begin
            step();
            chk($sformatf("prio_hold_%0d", k), {14'd0, grant}, (k == 9) ? 16'h0002 : 16'h0001);
        end
`else
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("nopre_hold_%0d", k), {14'd0, grant}, (k == 9) ? 16'h0001 : 16'h0002);
        end
        chk("nopre_nums", nums, 16'h1234);
`endif

        // Reset while owning returns to idle/blank and restores the pointer.
        reset_pulse("rst_own");
        step();
        chk("rst_own_tie", {14'd0, grant}, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ssd_display_arbiter.md
Name: ssd_display_arbiter

Overview:
- Shares the single 4-digit seven-segment display path (16-bit packed nibble word into the segment-display driver) between two requesters, e.g. the scrolling-text engine and a counter/stopwatch engine.
- Round-robin arbitration with a minimum ownership time measured in slow ticks, so a digit pattern stays readable.
- Contains its own tick divider and exports the tick so requesters can step their content in lockstep.
- Sits between the content generators and the segment-display driver.

Parameters:
- TICK_DIV, 50000000, clk cycles per slow tick; legal range ≥ 2.
- HOLD_TICKS, 3, minimum ticks an owner keeps the display before a pending other requester may take it; legal range ≥ 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  2  req[i]=1: client i wants the display; level-sensitive.
- nums0  input  16  client 0 packed digits {d3,d2,d1,d0}, 4 bits each.
- nums1  input  16  client 1 packed digits.
- grant  output  2  one-hot owner, 2'b00 when idle; registered.
- nums  output  16  packed digits to the segment-display driver; registered.
- tick  output  1  one-cycle pulse every TICK_DIV clk cycles.

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n); all state is cleared on rst_n=0 regardless of clk.
- Reset values:
  - grant=2'b00, nums=16'hFFFF (all digits BLANK_NIB=4'hF), tick=0.
  - Divider count=0, hold count=0, round-robin pointer last=1, so client 0 wins the first tie.
- Tick divider:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 exactly in the cycle where count==TICK_DIV-1.
  - Free-running; never stopped by arbitration.
- FSM states: IDLE, OWN0, OWN1. grant mirrors the state (IDLE=00, OWN0=01, OWN1=10).
- IDLE:
  - Only req[0] → OWN0; only req[1] → OWN1.
  - Both → the client != last wins.
  - Neither → stay IDLE.
  - The decision is made every cycle, not only on tick.
- OWNi:
  - Hold counter increments on each tick, saturating at HOLD_TICKS; it is 0 on entry to any OWN state.
  - req[i]=0 → release immediately regardless of hold: go to OWN(other) if req[other]=1, else IDLE.
  - req[i]=1, req[other]=1, hold==HOLD_TICKS → switch to OWN(other).
  - Otherwise stay in OWNi.
- last pointer: updated to i on every entry to OWNi.
- Direct OWN0↔OWN1 switching is legal; there is no IDLE gap cycle.
- nums:
  - Registered as nums <= nums(owner by next state) in the same edge the state updates; 16'hFFFF when next state is IDLE.
  - Latency: a req change is reflected on grant and nums after 1 clk edge.
  - Data changes on the owner's input appear 1 cycle later.
- Simultaneous events:
  - A tick in the same cycle hold reaches HOLD_TICKS counts, but the switch is evaluated on the registered hold value, so the switch occurs on the following cycle.
  - Release on req drop takes priority over hold logic.
- Reset mid-ownership: immediately returns to IDLE and blank output; the pointer returns to last=1.

Optional Feature:
- Macro: SSD_ARB_PRIO_EN.
- Defined: client 0 is high priority.
  - In OWN1, req[0]=1 preempts on the next edge regardless of hold.
  - In IDLE, req[0] always wins ties.
  - Client 1 still must wait HOLD_TICKS before taking the display from client 0.
- Undefined: pure round-robin with hold, as above.

Decomposition:
- Package ssd_pkg:
  - BLANK_NIB=4'hF and BLANK_WORD=16'hFFFF.
  - State encoding typedef {IDLE, OWN0, OWN1}.
  - Client index constants.
- Sub-module ssd_tick_gen (parameter TICK_DIV; ports clk, rst_n, tick) holds the divider; the arbiter instantiates it and forwards tick.

Test Plan (TICK_DIV=4, HOLD_TICKS=2):
- Reset then idle, req=00: grant=00, nums=16'hFFFF, tick pulses every 4 cycles; asserting rst_n=0 mid-count clears tick and count immediately.
- req=01, nums0=16'h0123: next edge grant=01, nums=16'h0123; change nums0 to 16'h1234 → nums=16'h1234 one cycle later.
- From idle, req=11 in one cycle: grant=01 first. Keep req=11: grant stays 01 until 2 ticks counted, then switches to 10 with nums=nums1. After 2 more ticks, back to 01.
- In OWN0 with req=11, drop req[0] before hold expires: next edge grant=10; then drop req[1]: grant=00, nums=16'hFFFF.
- With SSD_ARB_PRIO_EN: in OWN1 at hold=0, raise req[0] → grant=01 next edge. Without the macro, the same stimulus waits for 2 ticks.
